interrupt_controller: RTL and testbench

- Sequences hardware interrupts into the microcoded control unit by forcing a vector opcode into the instruction register at an instruction boundary.
- Owns the control unit's `reg_ir_load_override` and `mcc_rst_override` inputs, and drives the opcode onto the 8-bit data bus during injection.
- Provides per-line pending/mask/in-service tracking, fixed priority, and nesting for strictly higher priority only.

---
 rtl/interrupt_controller_pkg.sv | 24 ++
 rtl/interrupt_controller_priority_encoder.sv | 23 ++
 rtl/interrupt_controller.sv | 187 ++++++++++++++++++
 tb/tb_interrupt_controller.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: sequencer state encodings,
// control-vector bit positions of the EI/DI/RETI microcode signals, and the
// vector opcode helper.
package interrupt_controller_pkg;

    // Interrupt sequencer states
    typedef enum logic [1:0] {
        IRQ_IDLE   = 2'd0,
        IRQ_ARMED  = 2'd1,
        IRQ_INJECT = 2'd2,
        IRQ_LOAD   = 2'd3
    } irq_state_t;

    // Bit positions of the interrupt-related strobes in the control-unit signal vector
    localparam int SIG_EI   = 24;
    localparam int SIG_DI   = 25;
    localparam int SIG_RETI = 26;

    // Opcode forced into IR for a given line index (wraps at 8 bits)
    function automatic logic [7:0] vector_opcode(input logic [7:0] base, input logic [7:0] idx);
        return base + idx;
    endfunction

endpackage

// File: rtl/interrupt_controller_priority_encoder.sv
// Lowest-set-bit priority encoder: index of the lowest asserted request plus
// a valid flag. Index is 0 when nothing is requested.
module priority_encoder #(
    parameter int WIDTH = 4,
    localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    output logic [IDXW-1:0]  idx,
    output logic             valid
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        idx   = '0;
        valid = |req;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: latches request edges, applies mask / in-service
// ceiling / global enable, and at an instruction boundary forces a vector
// opcode into the control unit (micro-counter reset, then IR load).
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int         NUM_IRQ     = 4,
    parameter logic [7:0] VECTOR_BASE = 8'hF0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               mask_load,
    input  logic [NUM_IRQ-1:0] mask_in,
    input  logic               ie_set,
    input  logic               ie_clr,
    input  logic               reti,
    input  logic               inst_end,
    output logic               reg_ir_load_override,
    output logic               mcc_rst_override,
    output logic               data_oe,
    output logic [7:0]         inject_opcode,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] in_service,
    output logic               ie
);

    localparam int IDXW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    irq_state_t         state_reg, state_next;
    logic [IDXW-1:0]    vec_idx_reg, vec_idx_next;
    logic [NUM_IRQ-1:0] irq_prev_reg;
    logic [NUM_IRQ-1:0] pending_reg, pending_next;
    logic [NUM_IRQ-1:0] mask_reg;
    logic [NUM_IRQ-1:0] in_service_reg, in_service_next;
    logic               ie_reg, ie_next;

    logic               ir_override_reg, ir_override_next;
    logic               mcc_override_reg, mcc_override_next;
    logic               data_oe_reg, data_oe_next;
    logic [7:0]         opcode_reg, opcode_next;

    logic [NUM_IRQ-1:0] irq_rise;
    logic [NUM_IRQ-1:0] ceiling;
    logic [NUM_IRQ-1:0] eligible;
    logic [IDXW-1:0]    sel;
    logic               valid;
    logic [IDXW-1:0]    is_idx;
    logic               is_valid;
    logic               load_done;

    assign irq_rise  = irq & ~irq_prev_reg;
    assign load_done = (state_reg == IRQ_LOAD);

    // Lowest in-service line sets the ceiling: only strictly lower indices may nest
    priority_encoder #(.WIDTH(NUM_IRQ)) u_is_enc (
        .req   (in_service_reg),
        .idx   (is_idx),
        .valid (is_valid)
    );

    assign ceiling  = is_valid ? ((NUM_IRQ'(1) << is_idx) - NUM_IRQ'(1)) : '1;
    assign eligible = pending_reg & ~mask_reg & ceiling;

    priority_encoder #(.WIDTH(NUM_IRQ)) u_sel_enc (
        .req   (eligible),
        .idx   (sel),
        .valid (valid)
    );

    // Sequencer next state and the registered-output values for that state
    always_comb begin
        state_next        = state_reg;
        vec_idx_next      = vec_idx_reg;
        ir_override_next  = 1'b0;
        mcc_override_next = 1'b0;
        data_oe_next      = 1'b0;
        opcode_next       = 8'h00;
        case (state_reg)
            IRQ_IDLE: begin
                if (ie_reg && valid) begin
                    state_next = IRQ_ARMED;
                end
            end
            IRQ_ARMED: begin
                if (!(ie_reg && valid)) begin
                    state_next = IRQ_IDLE;
                end else if (inst_end) begin
                    vec_idx_next = sel;
                    state_next   = IRQ_INJECT;
                end
            end
            IRQ_INJECT: state_next = IRQ_LOAD;
            IRQ_LOAD:   state_next = IRQ_IDLE;
            default:    state_next = IRQ_IDLE;
        endcase
        // Outputs are registered, so they are decoded from the state being entered
        if (state_next == IRQ_INJECT) begin
            mcc_override_next = 1'b1;
            data_oe_next      = 1'b1;
            opcode_next       = vector_opcode(VECTOR_BASE, 8'(vec_idx_next));
        end else if (state_next == IRQ_LOAD) begin
            ir_override_next = 1'b1;
            data_oe_next     = 1'b1;
            opcode_next      = vector_opcode(VECTOR_BASE, 8'(vec_idx_next));
        end
    end

    // Pending / in-service / enable updates, including same-cycle precedence rules
    always_comb begin
        pending_next = pending_reg;
        if (load_done) begin
            pending_next[vec_idx_reg] = 1'b0;
        end
        pending_next = pending_next | irq_rise;

        in_service_next = in_service_reg;
        if (reti) begin
            in_service_next = in_service_reg & ~(in_service_reg & (~in_service_reg + NUM_IRQ'(1)));
        end
        if (load_done) begin
            in_service_next = in_service_next | (NUM_IRQ'(1) << vec_idx_reg);
        end

        ie_next = ie_reg;
        if (ie_set || reti) begin
            ie_next = 1'b1;
        end
        if (ie_clr || load_done) begin
            ie_next = 1'b0;
        end
    end

    // Sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IRQ_IDLE;
            vec_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            vec_idx_reg <= vec_idx_next;
        end
    end

    // Request, mask, in-service and enable bookkeeping registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_prev_reg   <= '0;
            pending_reg    <= '0;
            mask_reg       <= '1;
            in_service_reg <= '0;
            ie_reg         <= 1'b0;
        end else begin
            irq_prev_reg   <= irq;
            pending_reg    <= pending_next;
            in_service_reg <= in_service_next;
            ie_reg         <= ie_next;
            if (mask_load) begin
                mask_reg <= mask_in;
            end
        end
    end

    // Registered control-unit overrides and bus drive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_override_reg  <= 1'b0;
            mcc_override_reg <= 1'b0;
            data_oe_reg      <= 1'b0;
            opcode_reg       <= 8'h00;
        end else begin
            ir_override_reg  <= ir_override_next;
            mcc_override_reg <= mcc_override_next;
            data_oe_reg      <= data_oe_next;
            opcode_reg       <= opcode_next;
        end
    end

    assign reg_ir_load_override = ir_override_reg;
    assign mcc_rst_override     = mcc_override_reg;
    assign data_oe              = data_oe_reg;
    assign inject_opcode        = opcode_reg;
    assign pending              = pending_reg;
    assign in_service           = in_service_reg;
    assign ie                   = ie_reg;

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: stimulus tasks predict injections
// with a line-level model and queue them; a negedge monitor checks every
// override pulse against the queue head.
module tb_interrupt_controller;

    localparam int         N  = 4;
    localparam logic [7:0] VB = 8'hF0;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] irq = '0;
    logic         mask_load = 1'b0;
    logic [N-1:0] mask_in = '0;
    logic         ie_set = 1'b0;
    logic         ie_clr = 1'b0;
    logic         reti = 1'b0;
    logic         inst_end = 1'b0;
    logic         reg_ir_load_override;
    logic         mcc_rst_override;
    logic         data_oe;
    logic [7:0]   inject_opcode;
    logic [N-1:0] pending;
    logic [N-1:0] in_service;
    logic         ie;

    interrupt_controller #(.NUM_IRQ(N), .VECTOR_BASE(VB)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .irq                  (irq),
        .mask_load            (mask_load),
        .mask_in              (mask_in),
        .ie_set               (ie_set),
        .ie_clr               (ie_clr),
        .reti                 (reti),
        .inst_end             (inst_end),
        .reg_ir_load_override (reg_ir_load_override),
        .mcc_rst_override     (mcc_rst_override),
        .data_oe              (data_oe),
        .inject_opcode        (inject_opcode),
        .pending              (pending),
        .in_service           (in_service),
        .ie                   (ie)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] op;
        int         at;
    } exp_t;
    exp_t q[$];

    // Reference model: line-level view of the controller
    logic [N-1:0] m_pend, m_mask, m_is;
    logic         m_ie;

    function automatic logic [N-1:0] lowbit(input logic [N-1:0] v);
        return v & (~v + 4'd1);
    endfunction

    function automatic logic [N-1:0] model_eligible();
        logic [N-1:0] ceil;
        ceil = (m_is == '0) ? 4'hF : (lowbit(m_is) - 4'd1);
        return m_pend & ~m_mask & ceil;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pend = '0;
        m_mask = '1;
        m_is   = '0;
        m_ie   = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_pending"}, 32'(pending), 32'(m_pend));
        check({tag, "_in_service"}, 32'(in_service), 32'(m_is));
        check({tag, "_ie"}, 32'(ie), 32'(m_ie));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ir_ovr"}, 32'(reg_ir_load_override), 0);
        check({tag, "_mcc_ovr"}, 32'(mcc_rst_override), 0);
        check({tag, "_data_oe"}, 32'(data_oe), 0);
        check({tag, "_opcode"}, 32'(inject_opcode), 0);
        check({tag, "_pending"}, 32'(pending), 0);
        check({tag, "_in_service"}, 32'(in_service), 0);
        check({tag, "_ie"}, 32'(ie), 0);
    endtask

    // Monitor: every override pulse must match the head of the expectation queue
    logic last_mcc = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (mcc_rst_override) begin
                if (q.size() == 0) begin
                    check("spurious_mcc_override", 1, 0);
                end else begin
                    check("mcc_opcode", 32'(inject_opcode), 32'(q[0].op));
                    check("mcc_cycle", 32'(cyc), 32'(q[0].at + 1));
                    check("mcc_data_oe", 32'(data_oe), 1);
                end
            end
            if (reg_ir_load_override) begin
                if (q.size() == 0) begin
                    check("spurious_ir_override", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    $display("[TB] inject opcode=%02h expected=%02h cycle=%0d", inject_opcode, e.op, cyc);
                    check("ir_opcode", 32'(inject_opcode), 32'(e.op));
                    check("ir_cycle", 32'(cyc), 32'(e.at + 2));
                    check("ir_data_oe", 32'(data_oe), 1);
                    check("ir_after_mcc", 32'(last_mcc), 1);
                end
            end
        end
        last_mcc = mcc_rst_override;
    end

    task automatic set_mask(input logic [N-1:0] m);
        mask_load = 1'b1;
        mask_in   = m;
        tick();
        mask_load = 1'b0;
        m_mask    = m;
        $display("[TB] mask <= %b", m);
    endtask

    task automatic pulse_ie(input bit s, input bit c);
        ie_set = s;
        ie_clr = c;
        tick();
        ie_set = 1'b0;
        ie_clr = 1'b0;
        if (c) m_ie = 1'b0;
        else if (s) m_ie = 1'b1;
        $display("[TB] ie_set=%0d ie_clr=%0d", s, c);
    endtask

    task automatic raise(input logic [N-1:0] lines);
        irq = lines;
        m_pend = m_pend | lines;
        tick();
        irq = '0;
        tick();
        $display("[TB] irq edges %b", lines);
    endtask

    task automatic do_reti();
        reti = 1'b1;
        tick();
        reti = 1'b0;
        m_is = m_is & ~lowbit(m_is);
        m_ie = 1'b1;
        $display("[TB] reti");
    endtask

    // variant: 0 plain, 1 ie_clr in INJECT, 2 reti in LOAD, 3 edge on line in LOAD, 4 rst in LOAD
    task automatic fire(input int variant);
        logic [N-1:0] e;
        int           sel;
        bit           inj;
        repeat (3) tick();
        e   = model_eligible();
        inj = m_ie && (e != '0);
        sel = 0;
        for (int i = N - 1; i >= 0; i--) if (e[i]) sel = i;
        inst_end = 1'b1;
        if (inj) q.push_back('{VB + 8'(sel), cyc});
        $display("[TB] inst_end variant=%0d expect_inject=%0d line=%0d", variant, inj, sel);
        tick();
        inst_end = 1'b0;
        if (variant == 1) ie_clr = 1'b1;
        tick();
        ie_clr = 1'b0;
        if (variant == 2) reti = 1'b1;
        if (variant == 3 && inj) irq[sel] = 1'b1;
        if (variant == 4) begin
            #1 rst = 1'b1;
            #1 check_outputs_zero("rst_mid_load");
        end
        tick();
        reti = 1'b0;
        irq  = '0;
        if (variant == 4) begin
            q.delete();
            model_reset();
            repeat (2) tick();
            rst = 1'b0;
            tick();
        end else begin
            if (variant == 1) m_ie = 1'b0;
            if (variant == 2) begin
                m_is = m_is & ~lowbit(m_is);
                m_ie = 1'b1;
            end
            if (inj) begin
                m_pend[sel] = (variant == 3);
                m_is[sel]   = 1'b1;
                m_ie        = 1'b0;
            end
        end
        tick();
        tick();
        check("queue_drained", 32'(q.size()), 0);
        check_state("after_inst_end");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_outputs_zero("reset");
        rst = 1'b0;
        tick();

        // Basic injection
        set_mask('0);
        pulse_ie(1, 0);
        raise(4'b0100);
        check_state("basic_pending");
        fire(0);
        do_reti();

        // Priority: lower index first, then the other after reti
        raise(4'b1010);
        fire(0);
        do_reti();
        fire(0);
        do_reti();

        // Nesting: only strictly higher priority preempts
        raise(4'b0100);
        fire(0);
        pulse_ie(1, 0);
        raise(4'b1001);
        fire(0);
        do_reti();
        check_state("nest_reti");
        fire(0);
        do_reti();
        fire(0);
        do_reti();

        // Masking and global enable gating
        set_mask(4'b0010);
        raise(4'b0010);
        fire(0);
        pulse_ie(0, 1);
        set_mask('0);
        fire(0);
        pulse_ie(1, 0);
        fire(0);
        do_reti();

        // ie_set with ie_clr: clear wins; reti with nothing in service sets ie
        pulse_ie(1, 1);
        check_state("set_clr");
        do_reti();
        check_state("reti_empty");

        // Abort rules
        raise(4'b0001);
        repeat (3) tick();
        pulse_ie(0, 1);
        fire(0);
        pulse_ie(1, 0);
        fire(1);
        do_reti();

        // Same-cycle reti and LOAD; edge on the vectored line during LOAD
        raise(4'b0100);
        fire(0);
        pulse_ie(1, 0);
        raise(4'b0001);
        fire(2);
        do_reti();
        raise(4'b0010);
        fire(3);
        do_reti();
        fire(0);
        do_reti();

        // Reset during LOAD, then confirm the mask came back all ones
        raise(4'b0100);
        fire(4);
        pulse_ie(1, 0);
        raise(4'b0001);
        fire(0);
        set_mask('0);

        // Randomized operations against the model
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 6))
                0, 1: raise(4'($urandom_range(1, 15)));
                2:    set_mask(($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000);
                3:    pulse_ie(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
                4:    do_reti();
                default: fire($urandom_range(0, 3));
            endcase
            check_state("random");
        end

        check("final_queue_empty", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
